ipg_rresp_gen: RTL

//  Transmit-side read-response framer. Takes one read response (56b header, src/dst memory addresses,

---
 rtl/ipg_rresp_gen.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/ipg_rresp_gen.sv
// Read-response framer: buffers a whole payload, then emits FIRST/SRC/DST/payload/LAST
// 64b IPG blocks so the downstream frame never contains a gap it could avoid.
module ipg_rresp_gen #(
  parameter int MAX_PAYLOAD_BLKS = 16,
  parameter int LEN_W            = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [55:0] req_hdr,
  input  logic [55:0] req_src_addr,
  input  logic [55:0] req_dst_addr,
  input  logic        data_valid,
  output logic        data_ready,
  input  logic [55:0] data_in,
  input  logic        tx_ready,
  output logic        tx_ipg_valid,
  output logic [63:0] tx_ipg_data,
  output logic        err_len,
  output logic        err_gap
);

  localparam int MAX_LEN = 7 * MAX_PAYLOAD_BLKS;
  localparam int SL_W    = $clog2(MAX_LEN + 7);
  localparam int CNT_W   = $clog2(MAX_PAYLOAD_BLKS + 1);
  localparam int PTR_W   = (MAX_PAYLOAD_BLKS > 1) ? $clog2(MAX_PAYLOAD_BLKS) : 1;
  localparam logic [7:0] T_FIRST = 8'h2b;
  localparam logic [7:0] T_RRESP = 8'h1b;
  localparam logic [7:0] T_LAST  = 8'h0b;

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_HDR, S_SRC, S_DST, S_PAY} state_t;

  state_t             r_state;
  state_t             w_nextState;
  logic [55:0]        r_hdr, r_src, r_dst;
  logic [55:0]        r_buf [MAX_PAYLOAD_BLKS];
  logic [CNT_W-1:0]   r_nblk, r_lastIdx, r_wrPtr, r_rdPtr;
  logic [2:0]         r_lenMod;
  logic               r_zeroLen;
  logic               r_reqReady, r_dataReady, r_txValid, r_errLen, r_errGap;
  logic [63:0]        r_txData;

  logic               w_reqAcc, w_beatAcc, w_txAcc, w_lastBeat, w_lastBlk, w_lenTooBig;
  logic [SL_W-1:0]    w_lenSmall;
  logic [CNT_W-1:0]   w_reqNblk, w_rdNext;
  logic [2:0]         w_reqMod;
  logic [55:0]        w_hdrSel, w_payInfo;
  logic [63:0]        w_txDataNext;

  // Only lengths that fit the buffer are used past the too-long check, so the narrow slice suffices.
  assign w_lenTooBig = req_hdr[LEN_W-1:0] > LEN_W'(MAX_LEN);
  assign w_lenSmall  = req_hdr[SL_W-1:0];
  assign w_reqNblk   = CNT_W'((w_lenSmall + SL_W'(6)) / SL_W'(7));
  assign w_reqMod    = 3'(w_lenSmall % SL_W'(7));

  assign w_reqAcc   = req_valid && r_reqReady;
  assign w_beatAcc  = data_valid && r_dataReady;
  assign w_txAcc    = r_txValid && tx_ready;
  assign w_lastBeat = w_beatAcc && ((r_wrPtr + CNT_W'(1)) == r_nblk);
  assign w_lastBlk  = (r_rdPtr == r_lastIdx);

  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      S_IDLE: if (w_reqAcc && !w_lenTooBig) w_nextState = (w_reqNblk == '0) ? S_HDR : S_FILL;
      S_FILL: if (w_lastBeat) w_nextState = S_HDR;
      S_HDR:  if (w_txAcc) w_nextState = S_SRC;
      S_SRC:  if (w_txAcc) w_nextState = S_DST;
      S_DST:  if (w_txAcc) w_nextState = S_PAY;
      S_PAY:  if (w_txAcc && w_lastBlk) w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  // Output data is precomputed for the block that will be pending next cycle, so a stall holds it.
  always_comb begin
    w_rdNext = '0;
    if (r_state == S_PAY) w_rdNext = r_rdPtr + (w_txAcc ? CNT_W'(1) : CNT_W'(0));
    w_hdrSel  = (r_state == S_IDLE) ? req_hdr : r_hdr;
    w_payInfo = r_buf[w_rdNext[PTR_W-1:0]];
    if (w_rdNext == r_lastIdx) begin
      if (r_zeroLen) begin
        w_payInfo = '0;
      end else if (r_lenMod != 3'd0) begin
        for (int b = 0; b < 7; b++) begin
          if (3'(b) >= r_lenMod) w_payInfo[8*b +: 8] = 8'h00;
        end
      end
    end
    w_txDataNext = '0;
    unique case (w_nextState)
      S_HDR: w_txDataNext = {w_hdrSel, T_FIRST};
      S_SRC: w_txDataNext = {r_src, T_RRESP};
      S_DST: w_txDataNext = {r_dst, T_RRESP};
      S_PAY: w_txDataNext = {w_payInfo, (w_rdNext == r_lastIdx) ? T_LAST : T_RRESP};
      default: w_txDataNext = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_reqReady  <= 1'b1;
      r_dataReady <= 1'b0;
      r_txValid   <= 1'b0;
      r_txData    <= '0;
      r_errLen    <= 1'b0;
      r_errGap    <= 1'b0;
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_nblk      <= '0;
      r_lastIdx   <= '0;
      r_lenMod    <= '0;
      r_zeroLen   <= 1'b0;
      r_hdr       <= '0;
      r_src       <= '0;
      r_dst       <= '0;
    end else begin
      r_state     <= w_nextState;
      r_reqReady  <= (w_nextState == S_IDLE) && !w_reqAcc;
      r_dataReady <= (w_nextState == S_FILL);
      r_txValid   <= (w_nextState == S_HDR) || (w_nextState == S_SRC) ||
                     (w_nextState == S_DST) || (w_nextState == S_PAY);
      r_txData    <= w_txDataNext;
      r_errLen    <= w_reqAcc && w_lenTooBig;
      // A stall on the header is just waiting for a slot; later stalls break the frame.
      r_errGap    <= r_txValid && !tx_ready && (r_state != S_HDR);
      r_rdPtr     <= w_rdNext;
      if (w_reqAcc) begin
        r_hdr     <= req_hdr;
        r_src     <= req_src_addr;
        r_dst     <= req_dst_addr;
        r_nblk    <= w_reqNblk;
        r_lastIdx <= (w_reqNblk == '0) ? '0 : w_reqNblk - CNT_W'(1);
        r_lenMod  <= w_reqMod;
        r_zeroLen <= (w_reqNblk == '0);
        r_wrPtr   <= '0;
      end else if (w_beatAcc) begin
        r_wrPtr   <= r_wrPtr + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_beatAcc) r_buf[r_wrPtr[PTR_W-1:0]] <= data_in;
  end

  assign req_ready    = r_reqReady;
  assign data_ready   = r_dataReady;
  assign tx_ipg_valid = r_txValid;
  assign tx_ipg_data  = r_txData;
  assign err_len      = r_errLen;
  assign err_gap      = r_errGap;

endmodule
